// File: rtl/id_stage.sv
// id_stage: registered RV32I (+ Zicsr) instruction-decode stage.
//
// Purpose: decodes one instruction per cycle from fetch, flags illegal
// encodings and builds the operand-B immediate sign-extended to XLEN.
// Register-file read addresses are combinational from inst_i. All other
// decode results are registered with 1-cycle latency, optionally through a
// one-entry skid buffer so that in_ready is a pure register output.
//
// Ports:
//   clk, rst (async, active low), flush (sync kill of held instructions)
//   in_valid / in_ready, inst_i, inst_addr_i       : fetch side
//   rs1_addr_o, rs2_addr_o                          : regfile read addresses
//   out_valid / out_ready, out_*                    : execute side
module id_stage #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int CSR_EN  = 1,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_inst_addr,
  output logic [3:0]        out_op_class,
  output logic [2:0]        out_funct3,
  output logic              out_alt,
  output logic              out_rd_we,
  output logic [4:0]        out_rd_addr,
  output logic              out_csr_we,
  output logic [11:0]       out_csr_addr,
  output logic              out_imm_en,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_unsigned,
  output logic              out_illegal
);

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH, IMM_Z
  } imm_sel_e;

  typedef struct packed {
    logic [3:0]        op_class;
    logic [2:0]        funct3;
    logic              alt;
    logic              rd_we;
    logic [4:0]        rd_addr;
    logic              csr_we;
    logic [11:0]       csr_addr;
    logic              imm_en;
    logic [XLEN-1:0]   imm;
    logic              is_unsigned;
    logic              illegal;
    logic [ADDR_W-1:0] addr;
  } dec_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign rd     = inst_i[11:7];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];

  cls_e       cls;
  imm_sel_e   imm_sel;
  logic       ill, wr_rd, use_rs1, use_rs2, csr_wr, alt, uns;
  logic [11:0] csr_addr;
  logic [31:0] imm32;
  dec_t       dec_d;

  always_comb begin
    cls      = CLS_ILLEGAL;
    imm_sel  = IMM_NONE;
    ill      = 1'b0;
    wr_rd    = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    csr_wr   = 1'b0;
    alt      = 1'b0;
    uns      = 1'b0;
    csr_addr = 12'h000;

    case (opcode)
      OPC_LUI:   begin cls = CLS_LUI;   wr_rd = 1'b1; imm_sel = IMM_U; end
      OPC_AUIPC: begin cls = CLS_AUIPC; wr_rd = 1'b1; imm_sel = IMM_U; end
      OPC_JAL:   begin cls = CLS_JAL;   wr_rd = 1'b1; imm_sel = IMM_J; end
      OPC_JALR: begin
        cls = CLS_JALR; wr_rd = 1'b1; use_rs1 = 1'b1; imm_sel = IMM_I;
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_B;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        uns = (f3[2:1] == 2'b11);
      end
      OPC_LOAD: begin
        cls = CLS_LOAD; wr_rd = 1'b1; use_rs1 = 1'b1; imm_sel = IMM_I;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        uns = (f3 == 3'b100) || (f3 == 3'b101);
      end
      OPC_STORE: begin
        cls = CLS_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_S;
        ill = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        cls = CLS_OPIMM; wr_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'b001) begin
          imm_sel = IMM_SH;
          alt     = inst_i[30];
          ill     = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          imm_sel = IMM_SH;
          alt     = inst_i[30];
          ill     = (f7 != 7'h00) && (f7 != 7'h20);
        end else begin
          imm_sel = IMM_I;
          uns     = (f3 == 3'b011);
        end
      end
      OPC_OP: begin
        cls = CLS_OP; wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        alt = inst_i[30];
        uns = (f3 == 3'b011);
        ill = ((f7 != 7'h00) && (f7 != 7'h20)) ||
              ((f7 == 7'h20) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      OPC_FENCE: cls = CLS_FENCE;
      OPC_SYSTEM: begin
        cls      = CLS_SYSTEM;
        csr_addr = inst_i[31:20];
        if (f3 == 3'b000) begin
          ill = (inst_i != INST_ECALL) && (inst_i != INST_EBREAK);
        end else if ((f3 == 3'b100) || (CSR_EN == 0)) begin
          ill = 1'b1;
        end else begin
          wr_rd   = 1'b1;
          use_rs1 = !f3[2];
          imm_sel = f3[2] ? IMM_Z : IMM_NONE;
          // CSRRW(I) always writes; set/clear forms write only with a nonzero mask
          csr_wr  = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
        end
      end
      default: ill = 1'b1;
    endcase

    if (inst_i[1:0] != 2'b11) ill = 1'b1;
  end

  always_comb begin
    imm32 = 32'h0;
    case (imm_sel)
      IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      IMM_U: imm32 = {inst_i[31:12], 12'h000};
      IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase
  end

  always_comb begin
    dec_d             = '0;
    dec_d.op_class    = ill ? CLS_ILLEGAL : cls;
    dec_d.funct3      = f3;
    dec_d.alt         = alt && !ill;
    dec_d.rd_we       = wr_rd && !ill && (rd != 5'd0);
    dec_d.rd_addr     = rd;
    dec_d.csr_we      = csr_wr && !ill;
    dec_d.csr_addr    = csr_addr;
    dec_d.imm_en      = !ill && (imm_sel != IMM_NONE) && (imm_sel != IMM_B);
    dec_d.is_unsigned = uns && !ill;
    dec_d.illegal     = ill;
    dec_d.addr        = inst_addr_i;
    if (ill) begin
      dec_d.imm = '0;
    end else if (imm_sel == IMM_SH) begin
      dec_d.imm = XLEN'(inst_i[24:20]);
    end else if (imm_sel == IMM_Z) begin
      dec_d.imm = XLEN'(inst_i[19:15]);
    end else begin
      // signed cast makes the size cast sign-extend for XLEN=64
      dec_d.imm = XLEN'($signed(imm32));
    end
  end

  assign rs1_addr_o = (use_rs1 && !ill) ? rs1 : 5'd0;
  assign rs2_addr_o = (use_rs2 && !ill) ? rs2 : 5'd0;

  dec_t out_q, skid_q;
  logic out_valid_q, skid_valid_q;
  logic out_free, in_xfer;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (SKID_EN != 0) ? !skid_valid_q : out_free;
  assign in_xfer  = in_valid && in_ready;

  // Without the skid buffer in_xfer implies out_free, so the skid branch
  // never fires and skid_valid_q stays 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_xfer;
        if (in_xfer) out_q <= dec_d;
      end
    end else if ((SKID_EN != 0) && in_xfer) begin
      skid_q       <= dec_d;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_inst_addr = out_q.addr;
  assign out_op_class  = out_q.op_class;
  assign out_funct3    = out_q.funct3;
  assign out_alt       = out_q.alt;
  assign out_rd_we     = out_q.rd_we;
  assign out_rd_addr   = out_q.rd_addr;
  assign out_csr_we    = out_q.csr_we;
  assign out_csr_addr  = out_q.csr_addr;
  assign out_imm_en    = out_q.imm_en;
  assign out_imm       = out_q.imm;
  assign out_unsigned  = out_q.is_unsigned;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst, addr;

  logic        in_ready, out_valid, out_alt, out_rd_we, out_csr_we, out_imm_en, out_unsigned, out_illegal;
  logic [4:0]  rs1_addr, rs2_addr, out_rd_addr;
  logic [31:0] out_inst_addr, out_imm;
  logic [3:0]  out_op_class;
  logic [2:0]  out_funct3;
  logic [11:0] out_csr_addr;

  logic        b_in_ready, b_out_valid, b_out_alt, b_out_rd_we, b_out_csr_we, b_out_imm_en, b_out_unsigned, b_out_illegal;
  logic [4:0]  b_rs1_addr, b_rs2_addr, b_out_rd_addr;
  logic [31:0] b_out_inst_addr, b_out_imm;
  logic [3:0]  b_out_op_class;
  logic [2:0]  b_out_funct3;
  logic [11:0] b_out_csr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage #(.XLEN(32), .ADDR_W(32), .CSR_EN(1), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst), .inst_addr_i(addr), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst_addr(out_inst_addr),
    .out_op_class(out_op_class), .out_funct3(out_funct3), .out_alt(out_alt),
    .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr), .out_csr_we(out_csr_we),
    .out_csr_addr(out_csr_addr), .out_imm_en(out_imm_en), .out_imm(out_imm),
    .out_unsigned(out_unsigned), .out_illegal(out_illegal)
  );

  id_stage #(.XLEN(32), .ADDR_W(32), .CSR_EN(0), .SKID_EN(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .inst_i(inst), .inst_addr_i(addr), .rs1_addr_o(b_rs1_addr), .rs2_addr_o(b_rs2_addr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_inst_addr(b_out_inst_addr),
    .out_op_class(b_out_op_class), .out_funct3(b_out_funct3), .out_alt(b_out_alt),
    .out_rd_we(b_out_rd_we), .out_rd_addr(b_out_rd_addr), .out_csr_we(b_out_csr_we),
    .out_csr_addr(b_out_csr_addr), .out_imm_en(b_out_imm_en), .out_imm(b_out_imm),
    .out_unsigned(b_out_unsigned), .out_illegal(b_out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic        rd_we;
    logic [31:0] imm;
    logic        imm_en;
    logic        uns;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = 32'h0; addr = 32'h0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h exp 1", in_ready); end
    n_checks++; if (out_op_class !== 4'd0 || out_imm !== 32'h0 || out_inst_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got class %0d imm %h addr %h exp 0", out_op_class, out_imm, out_inst_addr); end
    n_checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_b: got valid %0h ready %0h exp 0/1", b_out_valid, b_in_ready); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'hFFF00093; addr = 32'h100;
    #1;
    n_checks++; if (rs1_addr !== 5'd0) begin n_fail++; $display("FAIL addi_rs1: got %0d exp 0", rs1_addr); end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h exp 1", out_valid); end
    n_checks++; if (out_op_class !== 4'd7) begin n_fail++; $display("FAIL addi_class: got %0d exp 7", out_op_class); end
    n_checks++; if (out_rd_addr !== 5'd1 || out_rd_we !== 1'b1) begin
      n_fail++; $display("FAIL addi_rd: got rd %0d we %0h exp 1/1", out_rd_addr, out_rd_we); end
    n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %h exp ffffffff", out_imm); end
    n_checks++; if (out_inst_addr !== 32'h100) begin n_fail++; $display("FAIL addi_addr: got %h exp 100", out_inst_addr); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0h exp 0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00208463; addr = 32'h200;
    #1;
    n_checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
      n_fail++; $display("FAIL beq_rs: got %0d/%0d exp 1/2", rs1_addr, rs2_addr); end
    step();
    inst = 32'h002081B3; addr = 32'h204;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_before: got %0h exp 1", in_ready); end
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL b_ready_stall: got %0h exp 0", b_in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready_full: got %0h exp 0", in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_inst_addr !== 32'h200 || out_op_class !== 4'd4) begin
      n_fail++; $display("FAIL skid_hold: got v %0h addr %h class %0d exp 1/200/4", out_valid, out_inst_addr, out_op_class); end
    n_checks++; if (out_imm !== 32'h8 || out_rd_we !== 1'b0 || out_imm_en !== 1'b0) begin
      n_fail++; $display("FAIL beq_fields: got imm %h we %0h en %0h exp 8/0/0", out_imm, out_rd_we, out_imm_en); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL b_ready_comb: got %0h exp 1", b_in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_inst_addr !== 32'h204 || out_op_class !== 4'd8) begin
      n_fail++; $display("FAIL skid_drain: got v %0h addr %h class %0d exp 1/204/8", out_valid, out_inst_addr, out_op_class); end
    n_checks++; if (out_rd_addr !== 5'd3 || out_rd_we !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_fields: got rd %0d we %0h ready %0h exp 3/1/1", out_rd_addr, out_rd_we, in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got %0h exp 0", out_valid); end
  endtask

  task automatic test_decode();
    vec_t v [8];
    v[0] = '{32'h123452B7, 4'd0,  1'b1, 32'h12345000, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0};
    v[1] = '{32'h40315093, 4'd7,  1'b1, 32'h00000003, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0};
    v[2] = '{32'h0020B233, 4'd8,  1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2};
    v[3] = '{32'h0020A223, 4'd6,  1'b0, 32'h00000004, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2};
    v[4] = '{32'hFFDFF0EF, 4'd2,  1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0};
    v[5] = '{32'hFFE0D303, 4'd5,  1'b1, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0};
    v[6] = '{32'h00000073, 4'd10, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    v[7] = '{32'h402081B3, 4'd8,  1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; inst = v[i].inst; addr = 32'h1000 + 32'(i * 4);
      #1;
      n_checks++; if (rs1_addr !== v[i].rs1 || rs2_addr !== v[i].rs2) begin
        n_fail++; $display("FAIL dec%0d_rs: got %0d/%0d exp %0d/%0d", i, rs1_addr, rs2_addr, v[i].rs1, v[i].rs2); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_inst_addr !== 32'h1000 + 32'(i * 4) || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dec%0d_flow: got v %0h addr %h rdy %0h", i, out_valid, out_inst_addr, in_ready); end
      n_checks++; if (out_op_class !== v[i].cls || out_rd_we !== v[i].rd_we || out_illegal !== 1'b0) begin
        n_fail++; $display("FAIL dec%0d_class: got %0d we %0h ill %0h exp %0d/%0h/0", i, out_op_class, out_rd_we, out_illegal, v[i].cls, v[i].rd_we); end
      n_checks++; if (out_imm !== v[i].imm || out_imm_en !== v[i].imm_en) begin
        n_fail++; $display("FAIL dec%0d_imm: got %h en %0h exp %h/%0h", i, out_imm, out_imm_en, v[i].imm, v[i].imm_en); end
      n_checks++; if (out_unsigned !== v[i].uns || out_alt !== v[i].alt) begin
        n_fail++; $display("FAIL dec%0d_flags: got uns %0h alt %0h exp %0h/%0h", i, out_unsigned, out_alt, v[i].uns, v[i].alt); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] ill_vec [6];
    ill_vec[0] = 32'h00000000; ill_vec[1] = 32'h40001033; ill_vec[2] = 32'h402091B3;
    ill_vec[3] = 32'h0020A463; ill_vec[4] = 32'h00200073; ill_vec[5] = 32'h0020B0E3;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; inst = ill_vec[i]; addr = 32'h2000 + 32'(i * 4);
      #1;
      n_checks++; if (rs1_addr !== 5'd0 || rs2_addr !== 5'd0) begin
        n_fail++; $display("FAIL ill%0d_rs: got %0d/%0d exp 0/0", i, rs1_addr, rs2_addr); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_op_class !== 4'd15 || out_illegal !== 1'b1) begin
        n_fail++; $display("FAIL ill%0d_class: got v %0h class %0d ill %0h exp 1/15/1", i, out_valid, out_op_class, out_illegal); end
      n_checks++; if (out_rd_we !== 1'b0 || out_csr_we !== 1'b0 || out_imm_en !== 1'b0) begin
        n_fail++; $display("FAIL ill%0d_we: got rd %0h csr %0h imm %0h exp 0", i, out_rd_we, out_csr_we, out_imm_en); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_csr();
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h300022F3; addr = 32'h3000;
    step();
    n_checks++; if (out_op_class !== 4'd10 || out_csr_addr !== 12'h300 || out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL csrrs_class: got %0d addr %h ill %0h exp 10/300/0", out_op_class, out_csr_addr, out_illegal); end
    n_checks++; if (out_csr_we !== 1'b0 || out_rd_we !== 1'b1 || out_rd_addr !== 5'd5) begin
      n_fail++; $display("FAIL csrrs_we: got csr %0h rd %0h rd_addr %0d exp 0/1/5", out_csr_we, out_rd_we, out_rd_addr); end
    n_checks++; if (b_out_valid !== 1'b1 || b_out_illegal !== 1'b1 || b_out_op_class !== 4'd15 || b_out_rd_we !== 1'b0) begin
      n_fail++; $display("FAIL csrrs_nocsr: got v %0h ill %0h class %0d we %0h exp 1/1/15/0", b_out_valid, b_out_illegal, b_out_op_class, b_out_rd_we); end
    inst = 32'h305FD073; addr = 32'h3004;
    #1;
    n_checks++; if (rs1_addr !== 5'd0) begin n_fail++; $display("FAIL csrrwi_rs1: got %0d exp 0", rs1_addr); end
    step();
    n_checks++; if (out_csr_we !== 1'b1 || out_rd_we !== 1'b0 || out_csr_addr !== 12'h305) begin
      n_fail++; $display("FAIL csrrwi_we: got csr %0h rd %0h addr %h exp 1/0/305", out_csr_we, out_rd_we, out_csr_addr); end
    n_checks++; if (out_imm !== 32'd31 || out_imm_en !== 1'b1) begin
      n_fail++; $display("FAIL csrrwi_imm: got %h en %0h exp 1f/1", out_imm, out_imm_en); end
    inst = 32'h34011073; addr = 32'h3008;
    #1;
    n_checks++; if (rs1_addr !== 5'd2) begin n_fail++; $display("FAIL csrrw_rs1: got %0d exp 2", rs1_addr); end
    step();
    n_checks++; if (out_csr_we !== 1'b1 || out_rd_we !== 1'b0 || out_imm_en !== 1'b0 || out_csr_addr !== 12'h340) begin
      n_fail++; $display("FAIL csrrw_fields: got csr %0h rd %0h en %0h addr %h exp 1/0/0/340", out_csr_we, out_rd_we, out_imm_en, out_csr_addr); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'hFFF00093; addr = 32'h500;
    step();
    inst = 32'h002081B3; addr = 32'h504;
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full: got %0h exp 0", in_ready); end
    flush = 1'b1; inst = 32'h00000013; addr = 32'h508;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: got v %0h rdy %0h exp 0/1", out_valid, in_ready); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_b: got %0h exp 0", b_out_valid); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_after: got %0h exp 0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'hFFF00093; addr = 32'h600;
    step();
    flush = 1'b1; inst = 32'h002081B3; addr = 32'h604;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_single: got v %0h rdy %0h exp 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got v %0h addr %h exp 0", out_valid, out_inst_addr); end
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'hFFF00093; addr = 32'h700;
    step();
    inst = 32'h002081B3; addr = 32'h704;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre: got v %0h rdy %0h exp 1/0", out_valid, in_ready); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_op_class !== 4'd0) begin
      n_fail++; $display("FAIL rst_async: got v %0h rdy %0h class %0d exp 0/1/0", out_valid, in_ready, out_op_class); end
    @(negedge clk);
    rst = 1'b1;
    step();
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h123452B7; addr = 32'h800;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_inst_addr !== 32'h800 || out_op_class !== 4'd0 || out_imm !== 32'h12345000) begin
      n_fail++; $display("FAIL rst_first: got v %0h addr %h class %0d imm %h exp 1/800/0/12345000", out_valid, out_inst_addr, out_op_class, out_imm); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_stale: got v %0h addr %h exp 0", out_valid, out_inst_addr); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_skid();
    test_decode();
    test_illegal();
    test_csr();
    test_flush();
    test_reset_midstall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered RV32I instruction-decode stage with valid/ready handshake on both sides. Sits between the fetch register and the execute/control stage.
- Decodes every RV32I base opcode plus Zicsr, and generates immediates sign-extended to a parametrised width.
- Flags illegal encodings.
- Drives register-file read addresses combinationally from the incoming instruction. All other decode results are presented one cycle later, optionally through a skid buffer.

Parameters:
XLEN, 32, datapath width for immediates; legal values 32 or 64.
ADDR_W, 32, instruction address width.
CSR_EN, 1, 1 = Zicsr decoded; 0 = every SYSTEM funct3 other than 000 is illegal.
SKID_EN, 1, 1 = one-entry skid buffer with registered in_ready; 0 = in_ready derived combinationally from out_ready.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of all held instructions.
in_valid  in  1  fetch has an instruction.
in_ready  out  1  stage accepts this cycle.
inst_i  in  32  instruction word.
inst_addr_i  in  ADDR_W  instruction address.
rs1_addr_o  out  5  regfile read address 1 (combinational from inst_i).
rs2_addr_o  out  5  regfile read address 2 (combinational from inst_i).
out_valid  out  1  decoded result valid.
out_ready  in  1  execute accepts.
out_inst_addr  out  ADDR_W  passed-through address.
out_op_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL.
out_funct3  out  3  funct3 field.
out_alt  out  1  funct7[5] for OP, and for OPIMM shifts; else 0.
out_rd_we  out  1  register write enable.
out_rd_addr  out  5  destination register.
out_csr_we  out  1  CSR write enable.
out_csr_addr  out  12  inst[31:20] for SYSTEM, else 0.
out_imm_en  out  1  operand B is the immediate.
out_imm  out  XLEN  immediate.
out_unsigned  out  1  unsigned compare/load.
out_illegal  out  1  illegal instruction.

Behaviour:
Reset (rst low, asynchronous):
- All registered outputs are 0, including out_valid.
- Skid buffer is empty; in_ready = 1.
- Reset mid-transfer discards all held instructions.

Handshake:
- A transfer occurs when valid && ready on the respective side. Latency from input transfer to out_valid is 1 cycle.
- Registered outputs are held stable while out_valid && !out_ready.
- SKID_EN=0: in_ready = !out_valid || out_ready.
- SKID_EN=1: in_ready = !skid_full (registered).
  - An input accepted while the output is stalled goes to the skid buffer.
  - The skid buffer drains to the output register on the next out_ready cycle.
  - Order is preserved. Sustained throughput is 1 per cycle.
- Flush has priority over an input transfer in the same cycle. Next cycle: out_valid = 0, skid empty, in_ready = 1. The same-cycle input is dropped.

Decoding:
- inst[1:0] != 2'b11 or an unknown opcode -> illegal.
- Further illegal cases:
  - BRANCH with funct3 010/011.
  - LOAD with funct3 011/110/111.
  - STORE with funct3 > 010.
  - OP with funct7 not 0x00/0x20, or funct7 0x20 with funct3 not 000/101.
  - SLLI with funct7 != 0.
  - SRLI/SRAI with funct7 not 0x00/0x20.
  - SYSTEM with funct3 100.
  - SYSTEM funct3 000 with inst not exactly ECALL (0x00000073) or EBREAK (0x00100073).
  - CSR forms when CSR_EN=0.
- When illegal: out_op_class = 15; rd_we, csr_we and imm_en are all 0.
- out_rd_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP and CSR ops, forced to 0 when rd == 0.
- out_csr_we:
  - CSRRW/CSRRWI: always 1.
  - CSRRS/CSRRC/CSRRSI/CSRRCI: 1 only when inst[19:15] != 0.
- rs1_addr_o = inst[19:15] for JALR, BRANCH, LOAD, STORE, OPIMM, OP, CSRRW/S/C; else 0.
- rs2_addr_o = inst[24:20] for BRANCH, STORE, OP; else 0.
- Illegal instructions drive both read addresses to 0.
- Immediates:
  - I/S/B/U/J formats are sign-extended from inst[31] to XLEN.
  - Shift immediates use shamt inst[24:20], zero-extended.
  - CSR-immediate forms use zimm inst[19:15], zero-extended.
  - All other cases: 0.
- out_imm_en = 1 for LUI, AUIPC, JAL, JALR, LOAD, STORE, OPIMM and CSR-immediate forms.
- out_unsigned = 1 for BLTU, BGEU, LBU, LHU, SLTIU, SLTU.

Test Plan:
- addi x1,x0,-1 (0xFFF00093, addr 0x100) with out_ready=1 -> next cycle: out_valid=1, class 7, rd 1, rd_we 1, imm 0xFFFFFFFF (XLEN=32), rs1_addr_o 0 on the same cycle as input.
- SKID_EN=1, out_ready=0, feed 0x00208463 (beq x1,x2,8) then 0x002081B3 (add x3,x1,x2) -> beq held on output; add captured in skid; in_ready drops. Raise out_ready -> beq then add emitted on consecutive cycles; imm 8 for beq.
- 0x00000000 and 0x40001033 (funct7 0x20 with SLL) -> class 15, illegal 1, rd_we 0, rs1/rs2 addr 0.
- csrrs x5,0x300,x0 (0x300022F3) -> csr_addr 0x300, csr_we 0, rd_we 1. Same instruction with CSR_EN=0 -> illegal. csrrwi x0,0x305,31 (0x305FD073) -> csr_we 1, rd_we 0, imm 31.
- Output stalled with skid full, pulse flush with in_valid=1 -> next cycle out_valid 0, in_ready 1; the same-cycle input never appears at the output.
- Assert rst low mid-stall -> out_valid 0 immediately (asynchronously); after release, the first new instruction emerges with 1-cycle latency.
